// File: rtl/axi4_dram_slave.sv
// AXI4 INCR burst slave over a word-addressed dual-port memory.
// The write and read channels each have their own FSM, with one outstanding burst per direction.
module axi4_dram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic [7:0]            awlen_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [7:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf
);
  localparam int IDX = $clog2(DEPTH);
  // Word pointers carry one spare bit so a burst running past the top cannot wrap back in range.
  localparam int WW = ADDR_WIDTH - 3;
  localparam logic [WW-1:0] DEPTH_W   = WW'(DEPTH);
  localparam logic [7:0]    WAIT_INIT = 8'(READ_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t        w_state;
  r_state_t        r_state;
  logic [WW-1:0]   w_word, r_word, r_sel;
  logic [7:0]      w_cnt, r_cnt, wait_cnt;
  logic            w_legal, w_oor, w_slv, r_legal;
  logic            w_hs, w_in, w_oor_all, w_slv_all, mem_we, r_in;
  logic [DATA_WIDTH-1:0] r_beat_data;
  logic [1:0]      r_beat_resp;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{awaddr_s_inf[3:0], araddr_s_inf[3:0]};

  assign w_hs      = (w_state == W_DATA) && wvalid_s_inf && wready_s_inf;
  assign w_in      = w_word < DEPTH_W;
  assign w_oor_all = w_oor || !w_in;
  assign w_slv_all = w_slv || !w_legal || (wlast_s_inf != (w_cnt == 8'd0));
  assign mem_we    = w_hs && w_legal && w_in;

  always_ff @(posedge clk) begin
    if (mem_we) mem[w_word[IDX-1:0]] <= wdata_s_inf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      awready_s_inf <= 1'b0;
      wready_s_inf  <= 1'b0;
      bvalid_s_inf  <= 1'b0;
      bid_s_inf     <= '0;
      bresp_s_inf   <= 2'b00;
      w_word        <= '0;
      w_cnt         <= 8'd0;
      w_legal       <= 1'b0;
      w_oor         <= 1'b0;
      w_slv         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_s_inf <= 1'b1;
          if (awvalid_s_inf && awready_s_inf) begin
            bid_s_inf     <= awid_s_inf;
            w_word        <= {1'b0, awaddr_s_inf[ADDR_WIDTH-1:4]};
            w_cnt         <= awlen_s_inf;
            w_legal       <= (awsize_s_inf == 3'b100) && (awburst_s_inf == 2'b01);
            w_oor         <= 1'b0;
            w_slv         <= 1'b0;
            awready_s_inf <= 1'b0;
            wready_s_inf  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_word <= w_word + WW'(1);
            w_cnt  <= w_cnt - 8'd1;
            w_oor  <= w_oor_all;
            w_slv  <= w_slv_all;
            // Error flags fold in the final beat too, so the response is ready the next cycle.
            if (w_cnt == 8'd0) begin
              wready_s_inf <= 1'b0;
              bvalid_s_inf <= 1'b1;
              bresp_s_inf  <= w_oor_all ? 2'b11 : (w_slv_all ? 2'b10 : 2'b00);
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready_s_inf) begin
            bvalid_s_inf  <= 1'b0;
            awready_s_inf <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // In R_DATA the word after the one on the bus is prefetched.
  assign r_sel = (r_state == R_DATA) ? r_word + WW'(1) : r_word;
  assign r_in  = r_sel < DEPTH_W;

  always_comb begin
    r_beat_data = '0;
    r_beat_resp = 2'b00;
    if (!r_legal)   r_beat_resp = 2'b10;
    else if (!r_in) r_beat_resp = 2'b11;
    else            r_beat_data = mem[r_sel[IDX-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      arready_s_inf <= 1'b0;
      rvalid_s_inf  <= 1'b0;
      rlast_s_inf   <= 1'b0;
      rdata_s_inf   <= '0;
      rresp_s_inf   <= 2'b00;
      rid_s_inf     <= '0;
      r_word        <= '0;
      r_cnt         <= 8'd0;
      wait_cnt      <= 8'd0;
      r_legal       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_s_inf <= 1'b1;
          if (arvalid_s_inf && arready_s_inf) begin
            rid_s_inf     <= arid_s_inf;
            r_word        <= {1'b0, araddr_s_inf[ADDR_WIDTH-1:4]};
            r_cnt         <= arlen_s_inf;
            r_legal       <= (arsize_s_inf == 3'b100) && (arburst_s_inf == 2'b01);
            wait_cnt      <= WAIT_INIT;
            arready_s_inf <= 1'b0;
            r_state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (wait_cnt == 8'd0) begin
            rvalid_s_inf <= 1'b1;
            rdata_s_inf  <= r_beat_data;
            rresp_s_inf  <= r_beat_resp;
            rlast_s_inf  <= (r_cnt == 8'd0);
            r_state      <= R_DATA;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        R_DATA: begin
          if (rready_s_inf) begin
            if (rlast_s_inf) begin
              rvalid_s_inf  <= 1'b0;
              rlast_s_inf   <= 1'b0;
              rdata_s_inf   <= '0;
              rresp_s_inf   <= 2'b00;
              arready_s_inf <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_word      <= r_word + WW'(1);
              r_cnt       <= r_cnt - 8'd1;
              rdata_s_inf <= r_beat_data;
              rresp_s_inf <= r_beat_resp;
              rlast_s_inf <= (r_cnt == 8'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_dram_slave.sv
// Randomized self-checking bench for axi4_dram_slave.
// Expected responses come from an array model of the memory, updated using plain burst arithmetic.
module tb_axi4_dram_slave;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 128;
  localparam int DEPTH      = 1024;
  localparam int READ_LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ID_WIDTH-1:0] awid = '0, arid = '0, bid, rid;
  logic [ADDR_WIDTH-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic [7:0] awlen = '0, arlen = '0;
  logic awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  logic [DATA_WIDTH-1:0] wdata = '0, rdata;

  always #5 clk = ~clk;

  axi4_dram_slave #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                    .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awsize_s_inf(awsize), .awburst_s_inf(awburst),
    .awlen_s_inf(awlen), .awvalid_s_inf(awvalid), .awready_s_inf(awready),
    .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
    .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
    .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
    .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
    .rvalid_s_inf(rvalid), .rready_s_inf(rready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_WIDTH-1:0] model_mem [DEPTH];
  logic [DATA_WIDTH-1:0] wbeats [256];
  logic [DATA_WIDTH-1:0] got_data [256];
  logic [1:0] got_resp [256];
  logic got_last [256];
  logic [ID_WIDTH-1:0] got_bid, got_rid;
  logic [1:0] got_bresp;
  int got_n, r_lat, r_span, stall_viol;
  bit b_prompt, aw_after, bv_after, ar_after, rv_after;

  // Reference model: a burst touches words addr/16 .. addr/16+len with no wrap.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int wlast_at);
    bit legal, oor, slv, drv_last;
    longint word;
    legal = (size == 3'b100) && (burst == 2'b01);
    oor = 1'b0;
    slv = !legal;
    for (int i = 0; i <= len; i++) begin
      word = longint'(addr >> 4) + i;
      if (word >= DEPTH) oor = 1'b1;
      else if (legal) model_mem[int'(word)] = wbeats[i];
      drv_last = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      if (drv_last != (i == len)) slv = 1'b1;
    end
    return oor ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endfunction

  function automatic void exp_beat(input logic [31:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst, input int i,
                                   output logic [DATA_WIDTH-1:0] d, output logic [1:0] r);
    longint word;
    word = longint'(addr >> 4) + i;
    if (!(size == 3'b100 && burst == 2'b01)) begin d = '0; r = 2'b10; end
    else if (word >= DEPTH) begin d = '0; r = 2'b11; end
    else begin d = model_mem[int'(word)]; r = 2'b00; end
  endfunction

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int wlast_at, input bit gaps);
    int i, guard;
    bit hs;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("[TB] FAIL aw_timeout: awready got 0 required 1");
      awvalid = 1'b0;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0;
    i = 0; guard = 0;
    while (i <= len && guard < 3000) begin
      wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata = wbeats[i];
      wlast = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      hs = wvalid && wready;
      @(negedge clk);
      if (hs) i++;
      guard++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_prompt = bvalid;
    bready = 1'b1;
    guard = 0;
    while (!bvalid && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("[TB] FAIL b_timeout: bvalid got 0 required 1");
    end
    got_bid = bid; got_bresp = bresp;
    @(negedge clk);
    bready = 1'b0;
    aw_after = awready; bv_after = bvalid;
  endtask

  // mode 0: rready high, 1: rready pattern 1,0,0,1, 2: random rready.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int guard;
    bit have_prev;
    logic [DATA_WIDTH-1:0] prev_d;
    logic [1:0] prev_r;
    logic prev_l;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    arvalid = 1'b0;
    r_lat = 0;
    while (!rvalid && r_lat < 100) begin @(negedge clk); r_lat++; end
    got_rid = rid;
    got_n = 0; r_span = 0; stall_viol = 0; have_prev = 1'b0;
    prev_d = '0; prev_r = 2'b00; prev_l = 1'b0;
    while (got_n <= len && r_span < 3000) begin
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) rready = (r_span % 4 == 0) || (r_span % 4 == 3);
      else rready = 1'($urandom_range(0, 1));
      if (have_prev && (!rvalid || rdata !== prev_d || rresp !== prev_r || rlast !== prev_l))
        stall_viol++;
      if (rvalid && rready) begin
        got_data[got_n] = rdata; got_resp[got_n] = rresp; got_last[got_n] = rlast;
        got_n++;
        have_prev = 1'b0;
      end else begin
        have_prev = rvalid; prev_d = rdata; prev_r = rresp; prev_l = rlast;
      end
      @(negedge clk);
      r_span++;
    end
    if (r_span >= 3000) begin
      vectors++; miscompares++;
      $display("[TB] FAIL r_timeout: beats got %0d required %0d", got_n, len + 1);
    end
    rready = 1'b0;
    ar_after = arready; rv_after = rvalid;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid} !== '0 || rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got aw=%b ar=%b w=%b b=%b r=%b rdata=%h required all 0",
               awready, arready, wready, bvalid, rvalid, rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got awready=%b arready=%b required 1 1", awready, arready);
    end
  endtask

  task automatic test_basic();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    for (int i = 0; i < 4; i++) wbeats[i] = {16{8'(8'h11 * (i + 1))}};
    exp_b = model_write(32'h100, 3, 3'b100, 2'b01, -1);
    axi_write(4'd3, 32'h100, 3, 3'b100, 2'b01, -1, 1'b0);
    vectors++;
    if (got_bid !== 4'd3 || got_bresp !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL basic_b: got bid=%0d bresp=%b required bid=3 bresp=%b", got_bid, got_bresp, exp_b);
    end
    vectors++;
    if (!b_prompt || !aw_after || bv_after) begin
      miscompares++;
      $display("[TB] FAIL basic_b_timing: got prompt=%b aw_after=%b bv_after=%b required 1 1 0",
               b_prompt, aw_after, bv_after);
    end
    axi_read(4'd5, 32'h100, 3, 3'b100, 2'b01, 0);
    vectors++;
    if (got_rid !== 4'd5 || got_n != 4 || r_lat != READ_LAT || !ar_after || rv_after) begin
      miscompares++;
      $display("[TB] FAIL basic_r: got rid=%0d beats=%0d lat=%0d ar=%b rv=%b required 5 4 %0d 1 0",
               got_rid, got_n, r_lat, ar_after, rv_after, READ_LAT);
    end
    for (int i = 0; i <= 3; i++) begin
      exp_beat(32'h100, 3'b100, 2'b01, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL basic_beat%0d: got %h/%b/%b required %h/%b/%b", i,
                 got_data[i], got_resp[i], got_last[i], ed, er, (i == 3));
      end
    end
  endtask

  task automatic test_long_read();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    int bad;
    for (int i = 0; i < 256; i++) wbeats[i] = {$urandom, $urandom, $urandom, $urandom};
    exp_b = model_write(32'h0, 255, 3'b100, 2'b01, -1);
    axi_write(4'd7, 32'h0, 255, 3'b100, 2'b01, -1, 1'b0);
    vectors++;
    if (got_bresp !== exp_b || got_bid !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL long_b: got bid=%0d bresp=%b required 7 %b", got_bid, got_bresp, exp_b);
    end
    axi_read(4'd9, 32'h0, 255, 3'b100, 2'b01, 0);
    vectors++;
    if (r_lat != READ_LAT || r_span != 256 || got_n != 256) begin
      miscompares++;
      $display("[TB] FAIL long_timing: got lat=%0d span=%0d beats=%0d required %0d 256 256",
               r_lat, r_span, got_n, READ_LAT);
    end
    bad = 0;
    for (int i = 0; i <= 255; i++) begin
      exp_beat(32'h0, 3'b100, 2'b01, i, ed, er);
      if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == 255)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL long_beats: got %0d bad beats required 0", bad);
    end
  endtask

  task automatic test_rready_stall();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er;
    axi_read(4'd2, 32'h40, 7, 3'b100, 2'b01, 1);
    vectors++;
    if (got_n != 8 || stall_viol != 0 || r_span != 16) begin
      miscompares++;
      $display("[TB] FAIL stall: got beats=%0d unstable=%0d span=%0d required 8 0 16", got_n, stall_viol, r_span);
    end
    for (int i = 0; i <= 7; i++) begin
      exp_beat(32'h40, 3'b100, 2'b01, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == 7)) begin
        miscompares++;
        $display("[TB] FAIL stall_beat%0d: got %h/%b/%b required %h/%b/%b", i,
                 got_data[i], got_resp[i], got_last[i], ed, er, (i == 7));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    logic [31:0] addr;
    addr = 32'(DEPTH * 16 - 16);
    wbeats[0] = {4{32'hCAFE_0001}};
    wbeats[1] = {4{32'hCAFE_0002}};
    exp_b = model_write(addr, 1, 3'b100, 2'b01, -1);
    axi_write(4'd1, addr, 1, 3'b100, 2'b01, -1, 1'b0);
    vectors++;
    if (got_bresp !== exp_b || exp_b !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL oor_b: got bresp=%b required %b", got_bresp, exp_b);
    end
    axi_read(4'd1, addr, 1, 3'b100, 2'b01, 0);
    for (int i = 0; i <= 1; i++) begin
      exp_beat(addr, 3'b100, 2'b01, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == 1)) begin
        miscompares++;
        $display("[TB] FAIL oor_beat%0d: got %h/%b/%b required %h/%b/%b", i,
                 got_data[i], got_resp[i], got_last[i], ed, er, (i == 1));
      end
    end
  endtask

  task automatic test_wlast_error();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    for (int i = 0; i < 3; i++) wbeats[i] = {$urandom, $urandom, $urandom, $urandom};
    exp_b = model_write(32'h2000, 2, 3'b100, 2'b01, 1);
    axi_write(4'd4, 32'h2000, 2, 3'b100, 2'b01, 1, 1'b0);
    vectors++;
    if (got_bresp !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL wlast_b: got bresp=%b required %b", got_bresp, exp_b);
    end
    axi_read(4'd4, 32'h2000, 2, 3'b100, 2'b01, 0);
    for (int i = 0; i <= 2; i++) begin
      exp_beat(32'h2000, 3'b100, 2'b01, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er) begin
        miscompares++;
        $display("[TB] FAIL wlast_beat%0d: got %h/%b required %h/%b", i, got_data[i], got_resp[i], ed, er);
      end
    end
  endtask

  task automatic test_illegal();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    for (int i = 0; i < 2; i++) wbeats[i] = {$urandom, $urandom, $urandom, $urandom};
    exp_b = model_write(32'h3000, 1, 3'b100, 2'b01, -1);
    axi_write(4'd6, 32'h3000, 1, 3'b100, 2'b01, -1, 1'b0);
    for (int i = 0; i < 2; i++) wbeats[i] = {$urandom, $urandom, $urandom, $urandom};
    exp_b = model_write(32'h3000, 1, 3'b011, 2'b01, -1);
    axi_write(4'd6, 32'h3000, 1, 3'b011, 2'b01, -1, 1'b0);
    vectors++;
    if (got_bresp !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL illegal_b: got bresp=%b required %b", got_bresp, exp_b);
    end
    axi_read(4'd6, 32'h3000, 1, 3'b100, 2'b01, 0);
    for (int i = 0; i <= 1; i++) begin
      exp_beat(32'h3000, 3'b100, 2'b01, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er) begin
        miscompares++;
        $display("[TB] FAIL illegal_keep%0d: got %h/%b required %h/%b", i, got_data[i], got_resp[i], ed, er);
      end
    end
    axi_read(4'd6, 32'h3000, 1, 3'b100, 2'b10, 0);
    for (int i = 0; i <= 1; i++) begin
      exp_beat(32'h3000, 3'b100, 2'b10, i, ed, er);
      vectors++;
      if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == 1)) begin
        miscompares++;
        $display("[TB] FAIL illegal_rd%0d: got %h/%b required %h/%b", i, got_data[i], got_resp[i], ed, er);
      end
    end
  endtask

  task automatic test_random();
    logic [DATA_WIDTH-1:0] ed;
    logic [1:0] er, exp_b;
    logic [31:0] addr;
    logic [2:0] size;
    logic [3:0] id;
    int len, bad;
    for (int n = 0; n < 16; n++) begin
      addr = 32'($urandom_range(0, 240) * 16 + $urandom_range(0, 15));
      len = $urandom_range(0, 15);
      size = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b100;
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) wbeats[i] = {$urandom, $urandom, $urandom, $urandom};
        exp_b = model_write(addr, len, size, 2'b01, -1);
        axi_write(id, addr, len, size, 2'b01, -1, 1'b1);
        vectors++;
        if (got_bid !== id || got_bresp !== exp_b) begin
          miscompares++;
          $display("[TB] FAIL rand_w%0d: got bid=%0d bresp=%b required %0d %b", n, got_bid, got_bresp, id, exp_b);
        end
      end else begin
        axi_read(id, addr, len, size, 2'b01, 2);
        bad = 0;
        for (int i = 0; i <= len; i++) begin
          exp_beat(addr, size, 2'b01, i, ed, er);
          if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == len)) bad++;
        end
        vectors++;
        if (got_rid !== id || got_n != len + 1 || r_lat != READ_LAT || stall_viol != 0 || bad != 0) begin
          miscompares++;
          $display("[TB] FAIL rand_r%0d: got rid=%0d beats=%0d lat=%0d unstable=%0d bad=%0d required %0d %0d %0d 0 0",
                   n, got_rid, got_n, r_lat, stall_viol, bad, id, len + 1, READ_LAT);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int guard, bv_seen;
    @(negedge clk);
    awid = 4'd8; awaddr = 32'(600 * 16); awlen = 8'd3; awsize = 3'b100; awburst = 2'b01; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = {4{32'hBEEF_0000}}; wlast = 1'b0;
    @(negedge clk);
    wdata = {4{32'hBEEF_0001}};
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got aw=%b ar=%b w=%b b=%b r=%b required 0",
               awready, arready, wready, bvalid, rvalid);
    end
    wvalid = 1'b0;
    bready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_awready: got %b required 1", awready);
    end
    bv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) bv_seen++;
      @(negedge clk);
    end
    bready = 1'b0;
    vectors++;
    if (bv_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_b: got %0d bvalid cycles required 0", bv_seen);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_long_read();
    test_rready_stall();
    test_out_of_range();
    test_wlast_error();
    test_illegal();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
